// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalt
  } fetch_state_e;

  localparam logic [31:0] END_OF_PROGRAM       = 32'h0000_0000;
  localparam int unsigned RESET_PC_DEFAULT     = 0;
  localparam int unsigned PC_INCREMENT_DEFAULT = 1;

endpackage

// File: rtl/fetch_output_reg.sv
// One-entry valid/ready register holding a fetched instruction and its PC.
module fetch_output_reg #(
  parameter int unsigned WORDSIZE         = 64,
  parameter int unsigned INSTRUCTION_SIZE = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        load,
  input  logic [INSTRUCTION_SIZE-1:0] load_instruction,
  input  logic [WORDSIZE-1:0]         load_pc,
  input  logic                        ready,
  output logic                        valid,
  output logic [INSTRUCTION_SIZE-1:0] instruction,
  output logic [WORDSIZE-1:0]         pc
);

  logic                        valid_q;
  logic [INSTRUCTION_SIZE-1:0] instr_q;
  logic [WORDSIZE-1:0]         pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush) begin
      // Payload is left as-is; only validity is dropped.
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      instr_q <= load_instruction;
      pc_q    <= load_pc;
    end else if (valid_q && ready) begin
      valid_q <= 1'b0;
    end
  end

  assign valid       = valid_q;
  assign instruction = instr_q;
  assign pc          = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// PC/state sequencer driving instruction memory and feeding decode.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned WORDSIZE         = 64,
  parameter int unsigned INSTRUCTION_SIZE = 32,
  parameter int unsigned MEMORY_SIZE      = 1024,
  parameter int unsigned PC_INCREMENT     = PC_INCREMENT_DEFAULT,
  parameter int unsigned RESET_PC         = RESET_PC_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic [WORDSIZE-1:0]         imem_addr,
  input  logic [INSTRUCTION_SIZE-1:0] imem_instruction,
  input  logic                        redirect_valid,
  input  logic [WORDSIZE-1:0]         redirect_pc,
  output logic                        if_valid,
  input  logic                        if_ready,
  output logic [INSTRUCTION_SIZE-1:0] if_instruction,
  output logic [WORDSIZE-1:0]         if_pc,
  output logic                        halted,
  output logic                        fault,
  output logic [31:0]                 fetch_count
);

  localparam logic [WORDSIZE-1:0] PcLimit = WORDSIZE'(MEMORY_SIZE * PC_INCREMENT);
  localparam logic [WORDSIZE-1:0] PcStep  = WORDSIZE'(PC_INCREMENT);
  localparam logic [WORDSIZE-1:0] PcReset = WORDSIZE'(RESET_PC);
  localparam logic [INSTRUCTION_SIZE-1:0] EopMarker = INSTRUCTION_SIZE'(END_OF_PROGRAM);

  fetch_state_e          state_q, state_d;
  logic [WORDSIZE-1:0]   pc_q, pc_d;
  logic                  fault_q, fault_d;
  logic [31:0]           count_q;
  logic                  flush, load, transfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= PcReset;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    flush   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        if (redirect_valid) begin
          pc_d  = redirect_pc;
          flush = 1'b1;
        end else if (pc_q >= PcLimit) begin
          // A held, unaccepted instruction survives and drains in HALT.
          fault_d = 1'b1;
          state_d = StHalt;
        end else if (!if_valid || if_ready) begin
          if (imem_instruction == EopMarker) begin
            state_d = StHalt;
          end else begin
            load = 1'b1;
            pc_d = pc_q + PcStep;
          end
        end
      end
      StHalt: ;
      default: state_d = StIdle;
    endcase
  end

  assign transfer = if_valid && if_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        count_q <= '0;
    else if (transfer) count_q <= count_q + 32'd1;
  end

  fetch_output_reg #(
    .WORDSIZE        (WORDSIZE),
    .INSTRUCTION_SIZE(INSTRUCTION_SIZE)
  ) u_out_reg (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .load            (load),
    .load_instruction(imem_instruction),
    .load_pc         (pc_q),
    .ready           (if_ready),
    .valid           (if_valid),
    .instruction     (if_instruction),
    .pc              (if_pc)
  );

  assign imem_addr   = pc_q;
  assign halted      = (state_q == StHalt);
  assign fault       = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a small behavioural instruction memory.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] imem_addr;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instruction;
  logic [63:0] if_pc;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:1023];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  assign imem_instruction = (imem_addr < 64'd1024) ? mem[imem_addr[9:0]] : 32'h0;

  fetch_controller u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .imem_addr       (imem_addr),
    .imem_instruction(imem_instruction),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instruction  (if_instruction),
    .if_pc           (if_pc),
    .halted          (halted),
    .fault           (fault),
    .fetch_count     (fetch_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, ".if_valid"}, {63'd0, if_valid}, 64'd0);
    check_eq({tag, ".if_instr"}, {32'd0, if_instruction}, 64'd0);
    check_eq({tag, ".if_pc"}, if_pc, 64'd0);
    check_eq({tag, ".halted"}, {63'd0, halted}, 64'd0);
    check_eq({tag, ".fault"}, {63'd0, fault}, 64'd0);
    check_eq({tag, ".count"}, {32'd0, fetch_count}, 64'd0);
    check_eq({tag, ".addr"}, imem_addr, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hdead_0000 | i;
    mem[0] = 32'h0000_2083;
    mem[1] = 32'h0800_2103;
    mem[2] = 32'h4010_81b3;
    mem[3] = 32'h0000_0000;
    rst_n = 1'b0;
    start = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'd0;
    if_ready = 1'b1;
    #1;
    check_reset_values("rst");
    #6 rst_n = 1'b1;
    step(3);
    check_eq("idle.valid", {63'd0, if_valid}, 64'd0);
    check_eq("idle.addr", imem_addr, 64'd0);

    // Straight-line run.
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("run.first_no_valid", {63'd0, if_valid}, 64'd0);
    step();
    check_eq("run.v0", {63'd0, if_valid}, 64'd1);
    check_eq("run.pc0", if_pc, 64'd0);
    check_eq("run.ins0", {32'd0, if_instruction}, 64'h0000_2083);
    check_eq("run.addr1", imem_addr, 64'd1);
    step();
    check_eq("run.pc1", if_pc, 64'd1);
    check_eq("run.cnt1", {32'd0, fetch_count}, 64'd1);
    step();
    check_eq("run.pc2", if_pc, 64'd2);
    check_eq("run.ins2", {32'd0, if_instruction}, 64'h4010_81b3);
    step();
    check_eq("run.halted", {63'd0, halted}, 64'd1);
    check_eq("run.cnt3", {32'd0, fetch_count}, 64'd3);
    check_eq("run.fault", {63'd0, fault}, 64'd0);
    check_eq("run.valid_off", {63'd0, if_valid}, 64'd0);
    check_eq("run.addr_hold", imem_addr, 64'd3);

    // Backpressure.
    do_reset();
    check_eq("bp.cnt_rst", {32'd0, fetch_count}, 64'd0);
    if_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      check_eq("bp.pc_hold", if_pc, 64'd0);
      check_eq("bp.ins_hold", {32'd0, if_instruction}, 64'h0000_2083);
      check_eq("bp.addr_hold", imem_addr, 64'd1);
      check_eq("bp.valid", {63'd0, if_valid}, 64'd1);
      step();
    end
    check_eq("bp.cnt0", {32'd0, fetch_count}, 64'd0);
    if_ready = 1'b1;
    step();
    check_eq("bp.pc1", if_pc, 64'd1);
    check_eq("bp.cnt1", {32'd0, fetch_count}, 64'd1);
    step();
    check_eq("bp.pc2", if_pc, 64'd2);
    step();
    check_eq("bp.cnt3", {32'd0, fetch_count}, 64'd3);
    check_eq("bp.halted", {63'd0, halted}, 64'd1);

    // Redirect drops the held instruction without counting it.
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    step(2);
    check_eq("rd.pc1", if_pc, 64'd1);
    check_eq("rd.cnt1", {32'd0, fetch_count}, 64'd1);
    redirect_valid = 1'b1;
    redirect_pc = 64'd0;
    step();
    redirect_valid = 1'b0;
    check_eq("rd.valid_drop", {63'd0, if_valid}, 64'd0);
    check_eq("rd.cnt_same", {32'd0, fetch_count}, 64'd1);
    check_eq("rd.addr0", imem_addr, 64'd0);
    step();
    check_eq("rd.pc0", if_pc, 64'd0);
    check_eq("rd.valid", {63'd0, if_valid}, 64'd1);

    // Out of range redirect.
    redirect_valid = 1'b1;
    redirect_pc = 64'd1024;
    step();
    redirect_valid = 1'b0;
    check_eq("oor.addr", imem_addr, 64'd1024);
    check_eq("oor.cnt", {32'd0, fetch_count}, 64'd1);
    step();
    check_eq("oor.fault", {63'd0, fault}, 64'd1);
    check_eq("oor.halted", {63'd0, halted}, 64'd1);
    check_eq("oor.valid", {63'd0, if_valid}, 64'd0);
    check_eq("oor.addr_hold", imem_addr, 64'd1024);

    // Start and redirect ignored in HALT.
    redirect_valid = 1'b1;
    redirect_pc = 64'd5;
    start = 1'b1;
    step(2);
    redirect_valid = 1'b0;
    start = 1'b0;
    check_eq("hg.addr", imem_addr, 64'd1024);
    check_eq("hg.halted", {63'd0, halted}, 64'd1);
    check_eq("hg.valid", {63'd0, if_valid}, 64'd0);
    check_eq("hg.fault", {63'd0, fault}, 64'd1);

    // Async reset between edges while an instruction is held.
    do_reset();
    if_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_eq("ar.pre_valid", {63'd0, if_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("ar");
    #1 rst_n = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'd7;
    if_ready = 1'b1;
    step(3);
    redirect_valid = 1'b0;
    check_eq("ar.idle_valid", {63'd0, if_valid}, 64'd0);
    check_eq("ar.idle_addr", imem_addr, 64'd0);
    check_eq("ar.idle_cnt", {32'd0, fetch_count}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequences the program counter for the combinational instruction_memory and hands fetched instructions to decode through a one-entry valid/ready output register. Handles start, backpressure, branch/jump redirects, end-of-program detection and out-of-range faults. Sits between instruction_memory and the decode stage; it is the only driver of the instruction memory address.

Parameters:
- WORDSIZE, 64, PC and address width.
- INSTRUCTION_SIZE, 32, instruction width.
- MEMORY_SIZE, 1024, number of instruction slots; valid word indices are 0..MEMORY_SIZE-1.
- PC_INCREMENT, 1, PC step per instruction. Memory is word-indexed, so imem_addr = pc.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; leaves IDLE.
- imem_addr  out  WORDSIZE  address to instruction_memory; equals pc.
- imem_instruction  in  INSTRUCTION_SIZE  combinational read data for imem_addr.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  WORDSIZE  redirect target.
- if_valid  out  1  output register holds an instruction.
- if_ready  in  1  decode accepts this cycle.
- if_instruction  out  INSTRUCTION_SIZE  held instruction.
- if_pc  out  WORDSIZE  PC of the held instruction.
- halted  out  1  controller is in HALT.
- fault  out  1  sticky; set when pc >= MEMORY_SIZE*PC_INCREMENT.
- fetch_count  out  32  number of instructions accepted by decode; wraps at 2^32.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, if_valid=0, if_instruction=0, if_pc=0, halted=0, fault=0, fetch_count=0.
- States:
  - IDLE: no fetch. start=1 -> RUN.
  - RUN: fetching (rules below).
  - HALT: no fetch, halted=1. Only reset leaves HALT; start is ignored.
- Capture condition: state=RUN and (if_valid=0 or if_ready=1).
- Handshake:
  - Transfer happens when if_valid & if_ready. fetch_count increments by 1 on every transfer, in any state.
  - While if_valid=1 and if_ready=0, if_instruction and if_pc hold stable; pc holds.
  - On a transfer without a new capture, if_valid clears.
- Capture (RUN), priority highest first:
  - 1. redirect_valid=1: pc <= redirect_pc; if_valid <= 0, discarding any held instruction even if if_ready=1 that cycle, and fetch_count does not increment; no capture. Redirect is also accepted while stalled.
  - 2. pc out of range: fault <= 1; state <= HALT; if_valid <= 0 unless a held instruction is still unaccepted, which stays until transferred.
  - 3. imem_instruction == 0 (end-of-program marker): state <= HALT; marker not delivered; pc holds.
  - 4. Otherwise: if_instruction <= imem_instruction; if_pc <= pc; if_valid <= 1; pc <= pc + PC_INCREMENT (WORDSIZE arithmetic, wraps silently).
- Latency: instruction at pc is visible on if_* one cycle after its capture edge. Sustained throughput is one per cycle while if_ready=1.
- Redirect in IDLE or HALT: ignored.
- Reset mid-operation: immediate return to reset values; any held instruction is lost.

Decomposition:
- Shared package fetch_pkg: state enum (IDLE, RUN, HALT), END_OF_PROGRAM constant (all zeros), and the default RESET_PC / PC_INCREMENT constants.
- One sub-module is natural: fetch_output_reg, the one-entry valid/ready register holding instruction, pc and valid, with flush input. The PC/state sequencer stays in the top module.

Test Plan:
- Straight-line run: memory [0]=0x00002083, [1]=0x08002103, [2]=0x401081B3, [3]=0; pulse start, if_ready=1 -> if_pc 0,1,2 on consecutive cycles; then halted=1, fetch_count=3, fault=0.
- Backpressure: same program, if_ready=0 for 3 cycles after first capture -> if_pc=0 and if_instruction=0x00002083 held stable, pc stays 1; after ready returns, sequence resumes with no loss or duplicate.
- Redirect: while if_valid=1 at pc=1, assert redirect_valid with redirect_pc=0 (if_ready=1) -> held instruction dropped, fetch_count unchanged; next if_pc=0.
- Out of range: redirect_pc=1024 -> fault=1, halted=1, if_valid=0, imem_addr stays 1024.
- Async reset mid-run: drop rst_n between clock edges -> all outputs at reset values immediately; state IDLE until next start.
- Idle/halt guards: redirect_valid and start in HALT -> no change; before start, if_valid stays 0 regardless of memory contents.
